// File: rtl/latch_gate_sched_pkg.sv
// Shared types and helpers for the latch gate scheduler: FSM states,
// latch op encodings and constant-width helpers.
package latch_sched_pkg;

  // Access sequencing states; every access walks SETUP -> OPEN -> HOLD -> ACK.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    OPEN  = 3'd2,
    HOLD  = 3'd3,
    ACK   = 3'd4
  } state_t;

  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_CLR = 2'b01;
  localparam logic [1:0] OP_PRE = 2'b10;

  // The unused encoding 2'b11 behaves as a clear so it can never reach PRE.
  function automatic logic [1:0] norm_op(input logic [1:0] op);
    return (op == 2'b11) ? OP_CLR : op;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Phase counter width: wide enough for the longest phase, plus one bit.
  function automatic int phase_cnt_w(input int s, input int o, input int h);
    return $clog2(max3(s, o, h)) + 1;
  endfunction

endpackage

// File: rtl/latch_gate_sched_rr_arbiter_n.sv
// Combinational round-robin arbiter: grants the first requester found at or
// after ptr+1 (mod NREQ). The caller registers the result.
module rr_arbiter_n
  import latch_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  // Scan NREQ positions starting just past the pointer; first hit wins.
  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (!any && req[IW'(j)]) begin
        any          = 1'b1;
        gnt[IW'(j)]  = 1'b1;
        idx          = IW'(j);
      end
    end
  end

endmodule

// File: rtl/latch_gate_sched.sv
// Round-robin scheduler sharing one bank of inverted-gate latches among
// NREQ requesters. Each access is sequenced as data setup, gate open (or
// clear/preset strobe), data hold and a one-cycle completion pulse.
//
// Handshake: a requester raises req[i] (level) and should keep it high until
// gnt[i] pulses. req_op/req_d are sampled only on the clock edge where the
// scheduler, sitting in IDLE, selects that requester. Once selected, the
// access always completes and gnt[i] pulses for exactly one cycle, even if
// req[i] has been dropped in the meantime.
module latch_gate_sched
  import latch_sched_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int OPEN_CYC  = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [2*NREQ-1:0]       req_op,
  input  logic [NREQ*WIDTH-1:0]   req_d,
  output logic [NREQ-1:0]         gnt,
  output logic                    busy,
  output logic [WIDTH-1:0]        lat_d,
  output logic                    lat_g,
  output logic                    lat_clr,
  output logic                    lat_pre,
  output state_t                  dbg_state
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = phase_cnt_w(SETUP_CYC, OPEN_CYC, HOLD_CYC);

  // Counter reload values: the counter runs down to zero within a phase.
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] OPEN_LAST  = CW'(OPEN_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     win_idx_q, win_idx_d;
  logic [NREQ-1:0]   win_oh_q, win_oh_d;
  logic [1:0]        win_op_q, win_op_d;
  logic [WIDTH-1:0]  win_data_q, win_data_d;

  logic [NREQ-1:0]   gnt_d;
  logic              busy_d;
  logic [WIDTH-1:0]  lat_d_d;
  logic              lat_g_d, lat_clr_d, lat_pre_d;

  logic [NREQ-1:0]   arb_gnt;
  logic [IW-1:0]     arb_idx;
  logic              arb_any;

  logic [1:0]        op_arr [NREQ];
  logic [WIDTH-1:0]  d_arr  [NREQ];

  // Split the flat per-requester buses into indexable arrays.
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign op_arr[g] = req_op[2*g +: 2];
    assign d_arr[g]  = req_d[WIDTH*g +: WIDTH];
  end

  rr_arbiter_n #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign dbg_state = state_q;

  // State register plus the winner context captured at the grant edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ptr_q      <= '0;
      win_idx_q  <= '0;
      win_oh_q   <= '0;
      win_op_q   <= OP_WR;
      win_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      win_idx_q  <= win_idx_d;
      win_oh_q   <= win_oh_d;
      win_op_q   <= win_op_d;
      win_data_q <= win_data_d;
    end
  end

  // Next-state logic: phase sequencing, counter reload on each phase entry.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ptr_d      = ptr_q;
    win_idx_d  = win_idx_q;
    win_oh_d   = win_oh_q;
    win_op_d   = win_op_q;
    win_data_d = win_data_q;
    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          state_d    = SETUP;
          cnt_d      = SETUP_LAST;
          win_idx_d  = arb_idx;
          win_oh_d   = arb_gnt;
          win_op_d   = norm_op(op_arr[arb_idx]);
          win_data_d = d_arr[arb_idx];
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = OPEN;
          cnt_d   = OPEN_LAST;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      OPEN: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = HOLD_LAST;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = ACK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ACK: begin
        state_d = IDLE;
        cnt_d   = '0;
        ptr_d   = win_idx_q;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state so every pin is a plain flop output.
  always_comb begin
    lat_d_d   = lat_d;
    if (state_d == SETUP && win_op_d == OP_WR) begin
      lat_d_d = win_data_d;
    end
    lat_g_d   = !(state_d == OPEN && win_op_d == OP_WR);
    lat_clr_d = (state_d == OPEN) && (win_op_d == OP_CLR);
    lat_pre_d = (state_d == OPEN) && (win_op_d == OP_PRE);
    gnt_d     = (state_d == ACK) ? win_oh_d : '0;
    busy_d    = (state_d != IDLE);
  end

  // Output registers; reset closes the gate and drops strobes immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt     <= '0;
      busy    <= 1'b0;
      lat_d   <= '0;
      lat_g   <= 1'b1;
      lat_clr <= 1'b0;
      lat_pre <= 1'b0;
    end else begin
      gnt     <= gnt_d;
      busy    <= busy_d;
      lat_d   <= lat_d_d;
      lat_g   <= lat_g_d;
      lat_clr <= lat_clr_d;
      lat_pre <= lat_pre_d;
    end
  end

endmodule

// File: doc/latch_gate_sched.md
Name: latch_gate_sched

Overview:
- Round-robin scheduler that shares one bank of WIDTH inverted-gate latches (async clear/preset, transparent while G low) among NREQ requesters.
- Sequences each access into fixed phases: data setup, gate open / strobe, data hold.
- Guarantees the latch gate never opens while CLR or PRE is asserted, and that D is stable around every gate edge.
- Sits between bus-side requesters and the latch bank's D/G/CLR/PRE pins.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, latch bank data width
SETUP_CYC, 1, cycles D is driven before the gate opens (>=1)
OPEN_CYC, 2, cycles gate is low or CLR/PRE is high (>=1)
HOLD_CYC, 1, cycles D is held after the gate closes (>=1)

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  reset, asynchronous, active-low
REQ  in  NREQ  per-requester request level
REQ_OP  in  2*NREQ  per-requester op: 00 write, 01 clear, 10 preset, 11 treated as clear
REQ_D  in  NREQ*WIDTH  per-requester write data
GNT  out  NREQ  one-hot completion pulse
BUSY  out  1  high whenever state != IDLE
LAT_D  out  WIDTH  latch bank D
LAT_G  out  1  latch gate, active-low; high = closed
LAT_CLR  out  1  latch async clear strobe
LAT_PRE  out  1  latch async preset strobe

Behaviour:
- Reset (RST_N low, takes effect immediately):
  - LAT_G=1; LAT_CLR=0; LAT_PRE=0; LAT_D=0; GNT=0; BUSY=0.
  - state=IDLE; round-robin pointer=0; phase counter=0.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- FSM states: IDLE, SETUP, OPEN, HOLD, ACK.
- IDLE:
  - If any REQ bit is high, grant the first set bit at or after ptr+1 (mod NREQ). After reset, ptr=0, so the search starts at index 1.
  - Latch the winner index, its op and its data, then go to SETUP.
  - If no REQ bit is high, stay in IDLE.
- SETUP:
  - Lasts SETUP_CYC cycles. LAT_D = latched data on a write, otherwise unchanged.
  - LAT_G=1, LAT_CLR=0, LAT_PRE=0. Then go to OPEN.
- OPEN:
  - Lasts OPEN_CYC cycles.
  - Write: LAT_G=0.
  - Clear (01 or 11): LAT_CLR=1, LAT_G stays 1.
  - Preset (10): LAT_PRE=1, LAT_G stays 1.
  - Then go to HOLD.
- HOLD:
  - Lasts HOLD_CYC cycles. LAT_G=1, LAT_CLR=0, LAT_PRE=0; LAT_D held. Then go to ACK.
- ACK:
  - Lasts 1 cycle. GNT[winner]=1; ptr=winner. Then go to IDLE, unconditionally.
- Latency:
  - GNT rises SETUP_CYC+OPEN_CYC+HOLD_CYC+1 cycles after the IDLE edge that sampled REQ. This is 5 cycles at defaults.
  - Back-to-back grants are separated by at least 1 IDLE cycle, giving a 6-cycle minimum period.
- Invariants:
  - LAT_CLR, LAT_PRE and !LAT_G are mutually exclusive on every cycle.
  - At most one GNT bit is high.
  - LAT_D does not change while LAT_G=0.
  - LAT_D retains its last written value between transactions; clear and preset do not alter it.
- Requesters hold REQ until GNT.
  - Dropping REQ mid-transaction does not abort it; GNT still pulses.
  - REQ_OP and REQ_D are sampled only at the grant edge.
- A requester holding REQ through its GNT is eligible again only after the other requesters, by round-robin.
- Reset asserted mid-OPEN forces LAT_G high and LAT_CLR/LAT_PRE low asynchronously. No GNT is issued for the aborted transaction.
- Phase counter width: $clog2(max(SETUP_CYC,OPEN_CYC,HOLD_CYC))+1. The counter reloads on every phase entry.

Decomposition:
- Shared package latch_sched_pkg holds:
  - the state enum (IDLE, SETUP, OPEN, HOLD, ACK);
  - the op encodings OP_WR=2'b00, OP_CLR=2'b01, OP_PRE=2'b10;
  - the function that maps 2'b11 to OP_CLR.
- One natural sub-module: rr_arbiter_n. It takes NREQ request bits and the pointer, and returns a one-hot grant plus an index. It is combinational, and its result is registered by the parent.

Test Plan:
- Reset then idle: RST_N low 3 cycles, no REQ -> LAT_G=1, LAT_CLR=0, LAT_PRE=0, LAT_D=0, GNT=0, BUSY=0 throughout.
- Single write: REQ[2]=1, op=00, data=8'hA5 -> LAT_D=A5 from the SETUP cycle; LAT_G low for exactly 2 cycles, starting 1 cycle after LAT_D updates; LAT_D stable 1 cycle after; GNT=4'b0100 pulse on the 5th cycle after the sampling edge.
- Clear and preset: REQ[0] op=01 -> LAT_CLR high 2 cycles with LAT_G=1. Then REQ[1] op=10 -> LAT_PRE high 2 cycles. LAT_D unchanged in both. Op 11 produces LAT_CLR, never LAT_PRE.
- Contention: REQ=4'b1111 held continuously after reset -> grant order 1,2,3,0,1, each GNT 6 cycles apart, each GNT a single-bit pulse.
- Reset mid-OPEN: assert RST_N low during a write with LAT_G=0 -> LAT_G goes to 1 before the next CLK edge; no GNT. After release, ptr=0, and a new REQ[3] write completes normally.
- Early REQ drop: REQ[1] pulsed for only the sampling cycle -> the full write sequence completes and GNT[1] pulses.
